ysyx_22051013_mul_ctrl: RTL

//  Sequencer for the pipelined Booth/Wallace 64x64 multiplier. Accepts one RV64M multiply from EX via

---
 rtl/ysyx_22051013_mul_pkg.sv | 31 +++
 rtl/ysyx_22051013_mul_opsel.sv | 59 +++++
 rtl/ysyx_22051013_mul_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_mul_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_mul_pkg
//   Shared definitions for the RV64M multiply sequencer: operation encodings
//   as presented by EX, FSM state encodings, default datapath latency and a
//   helper that classifies reserved operation codes.
// ---------------------------------------------------------------------------
package ysyx_22051013_mul_pkg;

  localparam int MUL_XLEN    = 64;
  localparam int MUL_LAT_DEF = 2;   // booth + wallace stage registers

  // Operation codes on in_op; 5..7 are reserved.
  typedef enum logic [2:0] {
    MUL_OP_MUL    = 3'd0,
    MUL_OP_MULH   = 3'd1,
    MUL_OP_MULHSU = 3'd2,
    MUL_OP_MULHU  = 3'd3,
    MUL_OP_MULW   = 3'd4
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= MUL_OP_MULW);
  endfunction

endpackage

// File: rtl/ysyx_22051013_mul_opsel.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_mul_opsel
//   Purely combinational operand/result shaping around the 66x66 datapath.
//   Ports:
//     op_in   [2:0]        operation of the request being launched
//     a, b    [XLEN-1:0]   rs1 / rs2
//     dp_a/b  [XLEN+1:0]   two-bit sign/zero extended operands
//     op_res  [2:0]        operation of the op in flight (registered)
//     prod    [2*XLEN-1:0] low bits of the datapath product
//     result  [XLEN-1:0]   selected / sign-extended architectural result
// ---------------------------------------------------------------------------
module ysyx_22051013_mul_opsel
  import ysyx_22051013_mul_pkg::*;
#(
  parameter int XLEN = MUL_XLEN
) (
  input  logic [2:0]        op_in,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN+1:0]   dp_a,
  output logic [XLEN+1:0]   dp_b,
  input  logic [2:0]        op_res,
  input  logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   result
);

  logic a_signed;
  logic b_signed;

  // Two extra bits let one signed multiplier serve every signedness mix:
  // an unsigned operand becomes a positive 66-bit value.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no
    // path through the case statement can infer a latch.
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULW: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MUL_OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    dp_a = a_signed ? {{2{a[XLEN-1]}}, a} : {2'b00, a};
    dp_b = b_signed ? {{2{b[XLEN-1]}}, b} : {2'b00, b};
  end

  always_comb begin
    result = '0;
    case (op_res)
      MUL_OP_MUL:                               result = prod[XLEN-1:0];
      MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: result = prod[2*XLEN-1:XLEN];
      MUL_OP_MULW:                              result = {{(XLEN-32){prod[31]}}, prod[31:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22051013_mul_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_mul_ctrl
//   Sequencer for the pipelined Booth/Wallace 64x64 multiplier. Accepts one
//   RV64M multiply from EX (valid/ready), launches the fixed-latency datapath,
//   captures the selected result and holds it for WB until taken. A flush
//   abandons any accepted or in-flight operation.
//
//   Ports:
//     clk, rst (async, active-high), flush
//     in_valid/in_ready, in_op[2:0], in_a/in_b[XLEN-1:0]      request side
//     out_valid/out_ready, out_result[XLEN-1:0]                result side
//     busy                                                     state != IDLE
//     dp_start, dp_a/dp_b[XLEN+1:0], dp_flush, dp_prod[2*XLEN-1:0]  datapath
//
//   Build option: define YSYX_22051013_MUL_FASTPATH_EN to complete requests
//   with a zero operand (low 32 bits for MULW) in one cycle without starting
//   the datapath. Undefined, every legal op goes through the datapath.
// ---------------------------------------------------------------------------
module ysyx_22051013_mul_ctrl
  import ysyx_22051013_mul_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,   // legal 1..7
  parameter int XLEN    = MUL_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              busy,
  output logic              dp_start,
  output logic [XLEN+1:0]   dp_a,
  output logic [XLEN+1:0]   dp_b,
  output logic              dp_flush,
  input  logic [2*XLEN-1:0] dp_prod
);

  // The product is valid MUL_LAT edges after the launch edge; loading
  // MUL_LAT-1 makes cnt reach zero in exactly that cycle.
  localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 1);

  mul_state_e      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            zero_fast;
  logic [XLEN-1:0] sel_result;

  ysyx_22051013_mul_opsel #(.XLEN(XLEN)) u_opsel (
    .op_in  (in_op),
    .a      (in_a),
    .b      (in_b),
    .dp_a   (dp_a),
    .dp_b   (dp_b),
    .op_res (op_q),
    .prod   (dp_prod),
    .result (sel_result)
  );

`ifdef YSYX_22051013_MUL_FASTPATH_EN
  // MULW only looks at the low words, so only they decide a zero product.
  always_comb begin
    if (in_op == MUL_OP_MULW) begin
      zero_fast = (in_a[31:0] == 32'd0) || (in_b[31:0] == 32'd0);
    end else begin
      zero_fast = (in_a == '0) || (in_b == '0);
    end
  end
`else
  assign zero_fast = 1'b0;
`endif

  assign accept   = in_valid && (state_q == ST_IDLE) && !flush;
  assign dp_start = accept && is_legal_op(in_op) && !zero_fast;
  assign dp_flush = flush;

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    if (flush) begin
      // Also covers a result being taken in the same cycle: either way the
      // controller ends up idle.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d = in_op;
            if (dp_start) begin
              cnt_d   = CNT_LOAD;
              state_d = ST_RUN;
            end else begin
              // Reserved op or zero-operand fast path: answer is zero.
              result_d = '0;
              state_d  = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q == 3'd0) begin
            result_d = sel_result;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

endmodule
